// File: rtl/ex_pkg.sv
// Shared types for the execute stage: ALU opcodes, branch funct3 codes and
// a small opcode-class helper.
package ex_pkg;

  localparam int XLEN = 64;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_ADDW  = 4'd10,
    ALU_SUBW  = 4'd11,
    ALU_SLLW  = 4'd12,
    ALU_SRLW  = 4'd13,
    ALU_SRAW  = 4'd14,
    ALU_PASSB = 4'd15
  } alu_op_e;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  // W ops compute on the low word and sign-extend bit 31
  function automatic logic is_word_op(input alu_op_e op);
    return (op == ALU_ADDW) || (op == ALU_SUBW) || (op == ALU_SLLW) ||
           (op == ALU_SRLW) || (op == ALU_SRAW);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, WB forwarding path, redirect and EX/MEM outputs of the
// execute stage. master = pipeline side driving EX, slave = ex_stage.
interface ex_stage_if #(
  parameter int DATA_WIDTH = 64,
  parameter int RF_SIZE    = 5
);
  logic                  stall_i, flush_i;
  logic [DATA_WIDTH-1:0] pc_i, imme_i;
  logic [RF_SIZE-1:0]    rd_i, rs1_i, rs2_i;
  logic [DATA_WIDTH-1:0] rs1val_i, rs2val_i;
  logic [3:0]            aluop_i;
  logic                  alusel2_i;
  logic [2:0]            brty_i, memwid_i;
  logic                  isbr_i, isjal_i, isjalr_i, isauipc_i;
  logic                  erd_i, ememread_i, ememwrite_i;
  logic                  wb_en_i;
  logic [RF_SIZE-1:0]    wb_rd_i;
  logic [DATA_WIDTH-1:0] wb_data_i;

  logic                  redirect_o;
  logic [DATA_WIDTH-1:0] target_o;
  logic [DATA_WIDTH-1:0] alures_o, storedata_o;
  logic [RF_SIZE-1:0]    rd_o;
  logic [2:0]            memwid_o;
  logic                  erd_o, ememread_o, ememwrite_o;
  logic [DATA_WIDTH-1:0] brcnt_o, redircnt_o;

  modport master (
    output stall_i, flush_i, pc_i, imme_i, rd_i, rs1_i, rs2_i, rs1val_i, rs2val_i,
           aluop_i, alusel2_i, brty_i, memwid_i, isbr_i, isjal_i, isjalr_i, isauipc_i,
           erd_i, ememread_i, ememwrite_i, wb_en_i, wb_rd_i, wb_data_i,
    input  redirect_o, target_o, alures_o, storedata_o, rd_o, memwid_o,
           erd_o, ememread_o, ememwrite_o, brcnt_o, redircnt_o
  );

  modport slave (
    input  stall_i, flush_i, pc_i, imme_i, rd_i, rs1_i, rs2_i, rs1val_i, rs2val_i,
           aluop_i, alusel2_i, brty_i, memwid_i, isbr_i, isjal_i, isjalr_i, isauipc_i,
           erd_i, ememread_i, ememwrite_i, wb_en_i, wb_rd_i, wb_data_i,
    output redirect_o, target_o, alures_o, storedata_o, rd_o, memwid_o,
           erd_o, ememread_o, ememwrite_o, brcnt_o, redircnt_o
  );
endinterface

// File: rtl/ex_stage_alu.sv
// Purely combinational RV64I integer ALU; W ops work on the low word and
// sign-extend the 32-bit result.
module alu
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);
  localparam int SHW = $clog2(DATA_WIDTH);

  alu_op_e        w_op;
  logic [31:0]    w_lo;
  logic [SHW-1:0] w_sh;
  logic [4:0]     w_shw;

  assign w_op  = alu_op_e'(op);
  assign w_sh  = b[SHW-1:0];
  assign w_shw = b[4:0];

  always_comb begin
    y    = '0;
    w_lo = '0;
    case (w_op)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_SLL:   y = a << w_sh;
      ALU_SLT:   y = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:  y = {{(DATA_WIDTH-1){1'b0}}, a < b};
      ALU_XOR:   y = a ^ b;
      ALU_SRL:   y = a >> w_sh;
      ALU_SRA:   y = $signed(a) >>> w_sh;
      ALU_OR:    y = a | b;
      ALU_AND:   y = a & b;
      ALU_ADDW:  w_lo = a[31:0] + b[31:0];
      ALU_SUBW:  w_lo = a[31:0] - b[31:0];
      ALU_SLLW:  w_lo = a[31:0] << w_shw;
      ALU_SRLW:  w_lo = a[31:0] >> w_shw;
      ALU_SRAW:  w_lo = $signed(a[31:0]) >>> w_shw;
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
    if (is_word_op(w_op)) y = {{(DATA_WIDTH-32){w_lo[31]}}, w_lo};
  end
endmodule

// File: rtl/ex_stage.sv
// RV64I execute stage: operand forwarding, ALU, branch/jump resolution with
// same-cycle redirect, and the EX/MEM register. EX_PERF_CNT_EN adds counters.
module ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int RF_SIZE    = 5
) (
  input logic       clk_i,
  input logic       rst_i,
  ex_stage_if.slave bus
);
  logic [DATA_WIDTH-1:0] r_alures, r_storedata;
  logic [RF_SIZE-1:0]    r_rd;
  logic [2:0]            r_memwid;
  logic                  r_erd, r_memread, r_memwrite;

  logic [DATA_WIDTH-1:0] w_rs1f, w_rs2f, w_opa, w_opb, w_aluy, w_res;
  logic                  w_cmp, w_taken, w_redirect, w_load;

  // A load in EX/MEM has no data yet; those hazards are stalled upstream
  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [RF_SIZE-1:0]    rs,
    input logic [DATA_WIDTH-1:0] rfval,
    input logic                  ex_ok,
    input logic [RF_SIZE-1:0]    ex_rd,
    input logic [DATA_WIDTH-1:0] ex_val,
    input logic                  wb_en,
    input logic [RF_SIZE-1:0]    wb_rd,
    input logic [DATA_WIDTH-1:0] wb_val
  );
    if (rs == '0)                 return '0;
    else if (ex_ok && ex_rd == rs) return ex_val;
    else if (wb_en && wb_rd == rs) return wb_val;
    else                           return rfval;
  endfunction

  assign w_rs1f = fwd(bus.rs1_i, bus.rs1val_i, r_erd & ~r_memread, r_rd, r_alures,
                      bus.wb_en_i, bus.wb_rd_i, bus.wb_data_i);
  assign w_rs2f = fwd(bus.rs2_i, bus.rs2val_i, r_erd & ~r_memread, r_rd, r_alures,
                      bus.wb_en_i, bus.wb_rd_i, bus.wb_data_i);

  assign w_opa = bus.isauipc_i ? bus.pc_i : w_rs1f;
  assign w_opb = bus.alusel2_i ? bus.imme_i : w_rs2f;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op (bus.aluop_i),
    .a  (w_opa),
    .b  (w_opb),
    .y  (w_aluy)
  );

  assign w_res = (bus.isjal_i | bus.isjalr_i) ? bus.pc_i + DATA_WIDTH'(4) : w_aluy;

  always_comb begin
    w_cmp = 1'b0;
    case (bus.brty_i)
      BR_EQ:   w_cmp = (w_rs1f == w_rs2f);
      BR_NE:   w_cmp = (w_rs1f != w_rs2f);
      BR_LT:   w_cmp = ($signed(w_rs1f) <  $signed(w_rs2f));
      BR_GE:   w_cmp = ($signed(w_rs1f) >= $signed(w_rs2f));
      BR_LTU:  w_cmp = (w_rs1f <  w_rs2f);
      BR_GEU:  w_cmp = (w_rs1f >= w_rs2f);
      default: w_cmp = 1'b0;
    endcase
  end

  // Static not-taken: anything that changes flow redirects fetch
  assign w_taken    = bus.isbr_i & w_cmp;
  assign w_redirect = ~bus.stall_i & (w_taken | bus.isjal_i | bus.isjalr_i);
  assign w_load     = ~bus.stall_i & ~bus.flush_i;

  assign bus.redirect_o = w_redirect;
  assign bus.target_o   = bus.isjalr_i
                        ? ((w_rs1f + bus.imme_i) & {{(DATA_WIDTH-1){1'b1}}, 1'b0})
                        : bus.pc_i + bus.imme_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_alures    <= '0;
      r_storedata <= '0;
      r_rd        <= '0;
      r_memwid    <= '0;
      r_erd       <= 1'b0;
      r_memread   <= 1'b0;
      r_memwrite  <= 1'b0;
    end else if (bus.flush_i) begin
      r_erd      <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
    end else if (!bus.stall_i) begin
      r_alures    <= w_res;
      r_storedata <= w_rs2f;
      r_rd        <= bus.rd_i;
      r_memwid    <= bus.memwid_i;
      r_erd       <= bus.erd_i;
      r_memread   <= bus.ememread_i;
      r_memwrite  <= bus.ememwrite_i;
    end
  end

  assign bus.alures_o    = r_alures;
  assign bus.storedata_o = r_storedata;
  assign bus.rd_o        = r_rd;
  assign bus.memwid_o    = r_memwid;
  assign bus.erd_o       = r_erd;
  assign bus.ememread_o  = r_memread;
  assign bus.ememwrite_o = r_memwrite;

`ifdef EX_PERF_CNT_EN
  logic [DATA_WIDTH-1:0] r_brcnt, r_redircnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_brcnt    <= '0;
      r_redircnt <= '0;
    end else begin
      if (w_load && bus.isbr_i) r_brcnt    <= r_brcnt + DATA_WIDTH'(1);
      if (w_redirect)           r_redircnt <= r_redircnt + DATA_WIDTH'(1);
    end
  end

  assign bus.brcnt_o    = r_brcnt;
  assign bus.redircnt_o = r_redircnt;
`else
  assign bus.brcnt_o    = '0;
  assign bus.redircnt_o = '0;
`endif
endmodule

// File: tb/tb_ex_stage.sv
// Execute-stage bench: directed scenarios plus a randomized run against a
// behavioural model of forwarding, ALU, branch and EX/MEM update rules.
module tb_ex_stage;
  import ex_pkg::*;

`ifdef EX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_if bus ();
  ex_stage dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int errs = 0;
  int checks = 0;

  // model of the EX/MEM register and counters
  logic [63:0] m_res, m_sd, m_brc, m_rdc;
  logic [4:0]  m_rd;
  logic [2:0]  m_mwid;
  logic        m_erd, m_mr, m_mw;

  task automatic clr_in();
    bus.stall_i = 0; bus.flush_i = 0; bus.pc_i = '0; bus.imme_i = '0;
    bus.rd_i = '0; bus.rs1_i = '0; bus.rs2_i = '0; bus.rs1val_i = '0; bus.rs2val_i = '0;
    bus.aluop_i = '0; bus.alusel2_i = 0; bus.brty_i = '0; bus.memwid_i = '0;
    bus.isbr_i = 0; bus.isjal_i = 0; bus.isjalr_i = 0; bus.isauipc_i = 0;
    bus.erd_i = 0; bus.ememread_i = 0; bus.ememwrite_i = 0;
    bus.wb_en_i = 0; bus.wb_rd_i = '0; bus.wb_data_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); clr_in(); rst = 1;
    @(posedge clk); #1; rst = 0;
    m_res = '0; m_sd = '0; m_brc = '0; m_rdc = '0; m_rd = '0; m_mwid = '0;
    m_erd = 0; m_mr = 0; m_mw = 0;
  endtask

  function automatic logic [63:0] m_fwd(input logic [4:0] rs, input logic [63:0] rfv);
    if (rs == 0) return 64'd0;
    if (m_erd && !m_mr && m_rd == rs) return m_res;
    if (bus.wb_en_i && bus.wb_rd_i == rs) return bus.wb_data_i;
    return rfv;
  endfunction

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] m_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    int s32;
    sa = a; sb = b; s32 = a[31:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << b[5:0];
      4'd3:  return (sa < sb) ? 64'd1 : 64'd0;
      4'd4:  return (a < b) ? 64'd1 : 64'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> b[5:0];
      4'd7:  return sa >>> b[5:0];
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return sx32(a[31:0] + b[31:0]);
      4'd11: return sx32(a[31:0] - b[31:0]);
      4'd12: return sx32(a[31:0] << b[4:0]);
      4'd13: return sx32(a[31:0] >> b[4:0]);
      4'd14: return sx32(s32 >>> b[4:0]);
      default: return b;
    endcase
  endfunction

  function automatic bit m_taken(input logic [2:0] ty, input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    sa = a; sb = b;
    case (ty)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return sa < sb;
      3'b101: return sa >= sb;
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    @(negedge clk); clr_in(); rst = 0;
    bus.isbr_i = 1; bus.brty_i = BR_EQ; bus.rd_i = 5'd1; bus.erd_i = 1;
    bus.alusel2_i = 1; bus.imme_i = 64'd3; bus.memwid_i = 3'd2;
    @(negedge clk); clr_in(); rst = 1;
    bus.aluop_i = ALU_ADD; bus.alusel2_i = 1; bus.imme_i = 64'd4; bus.rd_i = 5'd2; bus.erd_i = 1;
    @(posedge clk); #1;
    checks++;
    if ({bus.alures_o, bus.storedata_o, bus.rd_o, bus.memwid_o, bus.erd_o, bus.ememread_o, bus.ememwrite_o} !== '0)
      begin errs++; $display("FAIL reset_exmem: alures=%h sd=%h rd=%0d erd=%b expected all 0",
                             bus.alures_o, bus.storedata_o, bus.rd_o, bus.erd_o); end
    checks++;
    if (bus.brcnt_o !== 64'd0 || bus.redircnt_o !== 64'd0)
      begin errs++; $display("FAIL reset_cnt: brcnt=%0d redircnt=%0d expected 0", bus.brcnt_o, bus.redircnt_o); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_forward();
    @(negedge clk); clr_in();
    bus.aluop_i = ALU_ADD; bus.alusel2_i = 1; bus.imme_i = 64'd7; bus.rd_i = 5'd5; bus.erd_i = 1;
    @(posedge clk); #1;
    checks++;
    if (bus.alures_o !== 64'd7) begin errs++; $display("FAIL fwd_setup: alures=%h expected 7", bus.alures_o); end
    @(negedge clk); clr_in();
    bus.rs1_i = 5'd5; bus.rs1val_i = 64'd100; bus.alusel2_i = 1; bus.imme_i = 64'd1;
    bus.wb_en_i = 1; bus.wb_rd_i = 5'd5; bus.wb_data_i = 64'd9; bus.rd_i = 5'd6; bus.erd_i = 1;
    @(posedge clk); #1;
    checks++;
    if (bus.alures_o !== 64'd8) begin errs++; $display("FAIL fwd_exmem_prio: alures=%h expected 8", bus.alures_o); end
    @(negedge clk); clr_in();
    bus.alusel2_i = 1; bus.imme_i = 64'd7; bus.rd_i = 5'd5; bus.erd_i = 1; bus.ememread_i = 1;
    @(negedge clk); clr_in();
    bus.rs1_i = 5'd5; bus.rs1val_i = 64'd100; bus.alusel2_i = 1; bus.imme_i = 64'd1;
    bus.wb_en_i = 1; bus.wb_rd_i = 5'd5; bus.wb_data_i = 64'd9; bus.rd_i = 5'd6; bus.erd_i = 1;
    @(posedge clk); #1;
    checks++;
    if (bus.alures_o !== 64'd10) begin errs++; $display("FAIL fwd_wb_on_load: alures=%h expected 10", bus.alures_o); end
    @(negedge clk); clr_in();
    bus.rs1val_i = 64'd55; bus.alusel2_i = 1; bus.imme_i = 64'd1;
    bus.wb_en_i = 1; bus.wb_rd_i = 5'd0; bus.wb_data_i = 64'd9;
    @(posedge clk); #1;
    checks++;
    if (bus.alures_o !== 64'd1) begin errs++; $display("FAIL fwd_x0: alures=%h expected 1", bus.alures_o); end
  endtask

  task automatic test_branch();
    @(negedge clk); clr_in();
    bus.isbr_i = 1; bus.brty_i = BR_LT; bus.rs1_i = 5'd10; bus.rs2_i = 5'd11;
    bus.rs1val_i = '1; bus.rs2val_i = 64'd1; bus.pc_i = 64'h100; bus.imme_i = 64'h20;
    #1;
    checks++;
    if (bus.redirect_o !== 1'b1 || bus.target_o !== 64'h120)
      begin errs++; $display("FAIL blt: redirect=%b target=%h expected 1 / 120", bus.redirect_o, bus.target_o); end
    bus.brty_i = BR_LTU; #1;
    checks++;
    if (bus.redirect_o !== 1'b0) begin errs++; $display("FAIL bltu: redirect=%b expected 0", bus.redirect_o); end
    bus.brty_i = BR_GEU; #1;
    checks++;
    if (bus.redirect_o !== 1'b1) begin errs++; $display("FAIL bgeu: redirect=%b expected 1", bus.redirect_o); end
    bus.rs1val_i = 64'd5; bus.rs2val_i = 64'd5; bus.brty_i = 3'b010; #1;
    checks++;
    if (bus.redirect_o !== 1'b0) begin errs++; $display("FAIL br_undef: redirect=%b expected 0", bus.redirect_o); end
    bus.brty_i = BR_EQ; #1;
    checks++;
    if (bus.redirect_o !== 1'b1) begin errs++; $display("FAIL beq: redirect=%b expected 1", bus.redirect_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_jalr_stall();
    @(negedge clk); clr_in();
    bus.isjalr_i = 1; bus.rs1_i = 5'd12; bus.rs1val_i = 64'h1003; bus.pc_i = 64'h40;
    bus.rd_i = 5'd1; bus.erd_i = 1;
    #1;
    checks++;
    if (bus.redirect_o !== 1'b1 || bus.target_o !== 64'h1002)
      begin errs++; $display("FAIL jalr_target: redirect=%b target=%h expected 1 / 1002", bus.redirect_o, bus.target_o); end
    @(posedge clk); #1;
    checks++;
    if (bus.alures_o !== 64'h44 || bus.erd_o !== 1'b1 || bus.rd_o !== 5'd1)
      begin errs++; $display("FAIL jalr_link: alures=%h erd=%b rd=%0d expected 44 / 1 / 1", bus.alures_o, bus.erd_o, bus.rd_o); end
    @(negedge clk); clr_in();
    bus.stall_i = 1; bus.isjal_i = 1; bus.pc_i = 64'h200; bus.imme_i = 64'h8; bus.rd_i = 5'd2; bus.erd_i = 1;
    #1;
    checks++;
    if (bus.redirect_o !== 1'b0) begin errs++; $display("FAIL stall_redirect: redirect=%b expected 0", bus.redirect_o); end
    @(posedge clk); #1;
    checks++;
    if (bus.alures_o !== 64'h44 || bus.rd_o !== 5'd1 || bus.erd_o !== 1'b1)
      begin errs++; $display("FAIL stall_hold: alures=%h rd=%0d erd=%b expected 44 / 1 / 1", bus.alures_o, bus.rd_o, bus.erd_o); end
  endtask

  task automatic test_word_ops();
    @(negedge clk); clr_in();
    bus.aluop_i = ALU_ADDW; bus.rs1_i = 5'd13; bus.rs1val_i = 64'h7FFF_FFFF;
    bus.alusel2_i = 1; bus.imme_i = 64'd1; bus.rd_i = 5'd3; bus.erd_i = 1;
    @(posedge clk); #1;
    checks++;
    if (bus.alures_o !== 64'hFFFF_FFFF_8000_0000) begin errs++; $display("FAIL addw: alures=%h expected ffffffff80000000", bus.alures_o); end
    @(negedge clk); clr_in();
    bus.aluop_i = ALU_SRAW; bus.rs1_i = 5'd14; bus.rs1val_i = 64'h8000_0000;
    bus.alusel2_i = 1; bus.imme_i = 64'd4; bus.rd_i = 5'd3; bus.erd_i = 1;
    @(posedge clk); #1;
    checks++;
    if (bus.alures_o !== 64'hFFFF_FFFF_F800_0000) begin errs++; $display("FAIL sraw: alures=%h expected fffffffff8000000", bus.alures_o); end
    @(negedge clk); clr_in();
    bus.aluop_i = ALU_ADD; bus.isauipc_i = 1; bus.pc_i = 64'h1000; bus.alusel2_i = 1; bus.imme_i = 64'h2000;
    @(posedge clk); #1;
    checks++;
    if (bus.alures_o !== 64'h3000) begin errs++; $display("FAIL auipc: alures=%h expected 3000", bus.alures_o); end
  endtask

  task automatic test_flush_stall();
    @(negedge clk); clr_in();
    bus.alusel2_i = 1; bus.imme_i = 64'd5; bus.rd_i = 5'd7; bus.memwid_i = 3'd3;
    bus.erd_i = 1; bus.ememread_i = 1; bus.ememwrite_i = 1; bus.rs2_i = 5'd15; bus.rs2val_i = 64'hAB;
    @(posedge clk); #1;
    checks++;
    if ({bus.erd_o, bus.ememread_o, bus.ememwrite_o} !== 3'b111 || bus.storedata_o !== 64'hAB)
      begin errs++; $display("FAIL fs_load: ctl=%b sd=%h expected 111 / ab", {bus.erd_o, bus.ememread_o, bus.ememwrite_o}, bus.storedata_o); end
    @(negedge clk); clr_in();
    bus.flush_i = 1; bus.stall_i = 1; bus.alusel2_i = 1; bus.imme_i = 64'd99; bus.rd_i = 5'd9; bus.erd_i = 1;
    @(posedge clk); #1;
    checks++;
    if ({bus.erd_o, bus.ememread_o, bus.ememwrite_o} !== 3'b000 || bus.rd_o !== 5'd7 || bus.alures_o !== 64'd5)
      begin errs++; $display("FAIL flush_stall: ctl=%b rd=%0d alures=%h expected 000 / 7 / 5",
                             {bus.erd_o, bus.ememread_o, bus.ememwrite_o}, bus.rd_o, bus.alures_o); end
  endtask

  task automatic test_perf();
    do_reset();
    @(negedge clk); clr_in();
    bus.isbr_i = 1; bus.brty_i = BR_EQ; bus.rs1_i = 5'd1; bus.rs2_i = 5'd2;
    bus.rs1val_i = 64'd4; bus.rs2val_i = 64'd4;
    @(negedge clk); bus.brty_i = BR_NE;
    @(negedge clk); bus.brty_i = BR_LT; bus.rs1val_i = '1; bus.rs2val_i = 64'd1;
    @(posedge clk); #1;
    checks++;
    if (bus.brcnt_o !== (PERF ? 64'd3 : 64'd0) || bus.redircnt_o !== (PERF ? 64'd2 : 64'd0))
      begin errs++; $display("FAIL perf_cnt: brcnt=%0d redircnt=%0d expected %0d / %0d",
                             bus.brcnt_o, bus.redircnt_o, PERF ? 3 : 0, PERF ? 2 : 0); end
  endtask

  task automatic test_random();
    logic [63:0] a1, a2, t_res, t_tgt;
    bit          t_redir, ld;
    int          cls;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); clr_in();
      cls = $urandom_range(0, 5);
      bus.aluop_i   = 4'($urandom_range(0, 15));
      bus.alusel2_i = 1'($urandom_range(0, 1));
      bus.rd_i      = 5'($urandom_range(0, 7));
      bus.rs1_i     = 5'($urandom_range(0, 7));
      bus.rs2_i     = 5'($urandom_range(0, 7));
      bus.rs1val_i  = {$urandom, $urandom};
      bus.rs2val_i  = ($urandom_range(0, 3) == 0) ? bus.rs1val_i : {$urandom, $urandom};
      bus.imme_i    = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 63)) : {$urandom, $urandom};
      bus.pc_i      = {$urandom, $urandom};
      bus.brty_i    = 3'($urandom_range(0, 7));
      bus.memwid_i  = 3'($urandom_range(0, 7));
      bus.isbr_i    = (cls == 3);
      bus.isjal_i   = (cls == 4);
      bus.isjalr_i  = (cls == 5);
      bus.isauipc_i = (cls == 0) && ($urandom_range(0, 3) == 0);
      bus.erd_i     = (cls != 3) && ($urandom_range(0, 3) != 0);
      bus.ememread_i  = 1'($urandom_range(0, 3) == 0);
      bus.ememwrite_i = 1'($urandom_range(0, 3) == 0);
      bus.wb_en_i   = 1'($urandom_range(0, 1));
      bus.wb_rd_i   = 5'($urandom_range(0, 7));
      bus.wb_data_i = {$urandom, $urandom};
      bus.stall_i   = ($urandom_range(0, 7) == 0);
      bus.flush_i   = ($urandom_range(0, 9) == 0);
      #1;
      a1 = m_fwd(bus.rs1_i, bus.rs1val_i);
      a2 = m_fwd(bus.rs2_i, bus.rs2val_i);
      t_redir = !bus.stall_i && ((bus.isbr_i && m_taken(bus.brty_i, a1, a2)) || bus.isjal_i || bus.isjalr_i);
      t_tgt = bus.isjalr_i ? ((a1 + bus.imme_i) & ~64'd1) : bus.pc_i + bus.imme_i;
      t_res = (bus.isjal_i || bus.isjalr_i) ? bus.pc_i + 64'd4
            : m_alu(bus.aluop_i, bus.isauipc_i ? bus.pc_i : a1, bus.alusel2_i ? bus.imme_i : a2);
      checks++;
      if (bus.redirect_o !== t_redir || (t_redir && bus.target_o !== t_tgt))
        begin errs++; $display("FAIL rnd_redirect[%0d]: redirect=%b target=%h expected %b / %h",
                               n, bus.redirect_o, bus.target_o, t_redir, t_tgt); end
      ld = !bus.stall_i && !bus.flush_i;
      if (PERF && ld && bus.isbr_i) m_brc = m_brc + 1;
      if (PERF && t_redir)          m_rdc = m_rdc + 1;
      if (bus.flush_i) begin
        m_erd = 0; m_mr = 0; m_mw = 0;
      end else if (ld) begin
        m_res = t_res; m_sd = a2; m_rd = bus.rd_i; m_mwid = bus.memwid_i;
        m_erd = bus.erd_i; m_mr = bus.ememread_i; m_mw = bus.ememwrite_i;
      end
      @(posedge clk); #1;
      checks++;
      if (bus.alures_o !== m_res || bus.storedata_o !== m_sd || bus.rd_o !== m_rd || bus.memwid_o !== m_mwid ||
          {bus.erd_o, bus.ememread_o, bus.ememwrite_o} !== {m_erd, m_mr, m_mw})
        begin errs++; $display("FAIL rnd_exmem[%0d]: res=%h sd=%h rd=%0d ctl=%b expected %h / %h / %0d / %b",
                               n, bus.alures_o, bus.storedata_o, bus.rd_o, {bus.erd_o, bus.ememread_o, bus.ememwrite_o},
                               m_res, m_sd, m_rd, {m_erd, m_mr, m_mw}); end
      checks++;
      if (bus.brcnt_o !== m_brc || bus.redircnt_o !== m_rdc)
        begin errs++; $display("FAIL rnd_cnt[%0d]: brcnt=%0d redircnt=%0d expected %0d / %0d",
                               n, bus.brcnt_o, bus.redircnt_o, m_brc, m_rdc); end
    end
  endtask

  initial begin
    rst = 1;
    clr_in();
    repeat (2) @(posedge clk);
    test_reset();
    test_forward();
    test_branch();
    test_jalr_stall();
    test_word_ops();
    test_flush_stall();
    test_perf();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
